// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector.
// Samples one bit per data_valid cycle. It flags every occurrence of the loaded
// pattern, which can be 1..MAX_LEN bits long. Overlapping and non-overlapping
// matches are both supported. Detection is registered, so it appears one clock
// after the completing bit.
// Optional feature macro: SEQDET_MATCH_CNT_EN. When it is defined, a saturating
// match counter is built. When it is undefined, match_count is tied to 0.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 LEN_W       = 5,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(16'h000B),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic {FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_ok;
  logic               window_hit;
  logic               hit;

  // A load with an out-of-range length is treated as if the strobe were absent.
  assign cfg_ok = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // The history after taking the current bit. The oldest bit ends up at the top.
  assign hist_shift = {hist_q[MAX_LEN-2:0], data_in};

  // Build a mask with ones in the low len positions. Pattern bits above len are don't-care.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign window_hit = (((hist_shift ^ pattern_q) & len_mask) == '0);

  // Compute the next state and the next history, and decide whether this edge is a match.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit     = 1'b0;
    if (cfg_ok) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else if (data_valid) begin
      hist_d = hist_shift;
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + LEN_W'(1);
          if (fill_d == len_q) begin
            hit     = window_hit;
            state_d = RUN;
          end
        end
        RUN: hit = window_hit;
        default: state_d = FILL;
      endcase
      // In non-overlap mode, a match starts a fresh window. The matched bits age out of the mask before the next compare.
      if (hit && !overlap_q) begin
        fill_d  = '0;
        state_d = FILL;
      end
    end
  end

  // Configuration registers: they return to the defaults on reset and take new values on a legal load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
    end else if (cfg_ok) begin
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
    end
  end

  // FSM, history, fill counter and the registered detect flag.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every flop samples values from before the edge.
    if (!reset) begin
      state_q  <= FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      detected <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      detected <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter. A clear takes priority over a coincident match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog.
// Each driven cycle pushes its expected detect flag and count to a scoreboard.
// The entry is popped and compared just after the clock edge that produces it.
// The counter is built with CNT_W=2 so that saturation is reached quickly.
// Expected counts follow SEQDET_MATCH_CNT_EN.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               data_in;
  logic               data_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  typedef struct {
    string            tag;
    logic             det;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  seq_detector_prog #(
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W),
    .DEF_PATTERN (16'h000B),
    .DEF_LEN     (4),
    .DEF_OVERLAP (1'b1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .detected    (detected),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, push the expectation, then compare after the edge. Strobes drop back afterwards.
  task automatic step(input string tag, input logic d, input logic v, input logic exp_det);
    exp_t e;
    data_in    = d;
    data_valid = v;
`ifdef SEQDET_MATCH_CNT_EN
    if (!reset || cnt_clr)                 exp_cnt = '0;
    else if (exp_det && (exp_cnt != '1))   exp_cnt = exp_cnt + 1'b1;
`else
    exp_cnt = '0;
`endif
    e.tag = tag;
    e.det = exp_det;
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " det"}, {31'd0, detected}, {31'd0, e.det});
    check({e.tag, " cnt"}, {30'd0, match_count}, {30'd0, e.cnt});
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    reset    = 1'b1;
  endtask

  // Send a string of bits with one valid bit per cycle. exp marks the cycles where a detect is expected.
  task automatic send(input string tag, input string bits, input string exp);
    for (int i = 0; i < bits.len(); i++) begin
      step($sformatf("%s[%0d]", tag, i), bits[i] == "1", 1'b1, exp[i] == "1");
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic ovl, input logic clr);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    cnt_clr     = clr;
    step(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; data_in = 1'b0; data_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    exp_cnt = '0;

    // Reset state
    reset = 1'b0;
    step("rst", 1'b1, 1'b1, 1'b0);

    // 1: detection with the default configuration
    send("t1", "1011", "0001");
    idle("t1 idle", 1);

    // 2: overlap, then non-overlap replay
    load("t2 ld ovl", 16'h000B, 5'd4, 1'b1, 1'b1);
    send("t2 ovl", "1011011", "0001001");
    load("t2 ld novl", 16'h000B, 5'd4, 1'b0, 1'b1);
    send("t2 novl", "1011011", "0001000");

    // 3: eight-bit pattern with a valid gap, then a near-miss stream
    load("t3 ld", 16'h00A5, 5'd8, 1'b1, 1'b1);
    send("t3 a", "1010", "0000");
    idle("t3 gap", 3);
    send("t3 b", "0101", "0001");
    send("t3 miss", "11001010", "00000000");

    // Full-width pattern and don't-care upper pattern bits
    load("w16 ld", 16'hBEEF, 5'd16, 1'b1, 1'b1);
    send("w16", "1011111011101111", "0000000000000001");
    load("dc ld", 16'hFFF5, 5'd3, 1'b1, 1'b1);
    send("dc", "10101", "00101");
    load("b2b ld", 16'h0003, 5'd2, 1'b1, 1'b1);
    send("b2b", "111", "011");

    // 4: a reset mid-pattern clears the history and restores the default configuration
    load("t4 ld", 16'h0033, 5'd6, 1'b1, 1'b0);
    send("t4 a", "101", "000");
    reset = 1'b0;
    step("t4 rst", 1'b1, 1'b1, 1'b0);
    send("t4 b", "1", "0");
    send("t4 c", "1011", "0001");

    // 5: single-bit pattern drives the counter into saturation; clear wins over a match
    load("t5 ld", 16'h0001, 5'd1, 1'b1, 1'b1);
    send("t5", "11111", "11111");
    cnt_clr = 1'b1;
    step("t5 clr", 1'b1, 1'b1, 1'b1);
    idle("t5 idle", 1);

    // 6: illegal loads leave the configuration and history intact
    load("t6 ld", 16'h000B, 5'd4, 1'b1, 1'b1);
    send("t6 a", "101", "000");
    load("t6 len0", 16'h0000, 5'd0, 1'b0, 1'b0);
    load("t6 len17", 16'h0000, 5'd17, 1'b0, 1'b0);
    send("t6 b", "1", "1");
    // A load coincident with the completing bit discards that bit
    send("t6 c", "101", "000");
    cfg_pattern = 16'h000B; cfg_len = 5'd4; cfg_overlap = 1'b1; cfg_load = 1'b1;
    step("t6 ldhit", 1'b1, 1'b1, 1'b0);
    idle("t6 idle", 1);
    send("t6 d", "1011", "0001");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
